// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t   : FSM state encoding (IDLE, ADD, DONE)
//   NIBBLE_W  : width of one datapath slice
//   idx_width : width of the nibble index counter, clog2(nibbles) with a minimum of 1
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice built from four full adders.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder: sequences 4*NIBBLES-bit operands through one 4-bit
// ripple-carry slice, one nibble per clock, with a registered inter-nibble carry.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf signed-overflow port).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE, 0 during rst)
//   in1, in2, cin       : operands and carry-in, captured on accept
//   out_valid/out_ready : result handshake (result held until taken)
//   sum, cout           : registered (in1+in2+cin) mod 2^W and top carry
//   ovf                 : signed overflow (SERIAL_ADD_OVF_EN only)
module nibble_serial_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in1,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in2,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                          ovf
`endif
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned KW = idx_width(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t              state;
    logic [KW-1:0]       k;
    logic                carry;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                co_nib;

    assign a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];

    nibble_add4 u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry),
        .s  (s_nib),
        .co (co_nib)
    );

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        carry <= cin;
                        k     <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[k*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= co_nib;
                    if (k == K_LAST) begin
                        cout      <= co_nib;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        // carry into bit 3 of the slice is recovered as a^b^s
                        ovf       <= (a_nib[3] ^ b_nib[3] ^ s_nib[3]) ^ co_nib;
`endif
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4).
// Checks ovf as well when built with SERIAL_ADD_OVF_EN.
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one add, scramble inputs after capture, wait for the result,
    // check latency and values, then hand the result off.
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int unsigned cyc;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in1 = a; in2 = b; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in1 = '1; in2 = '1; cin = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, NIBBLES);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        int unsigned acc [2];
        int unsigned n_acc;

        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        do_add("t1", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
        do_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_add("t4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_add("t5", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_add("t6", 16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held for 10 cycles, in_valid ignored in DONE.
        in1 = 16'h1234; in2 = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            tick();
            seen++;
        end
        check("bp_latency", seen, NIBBLES);
        in_valid = 1'b1; in1 = 16'hFFFF; in2 = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_sum", 32'(sum), 32'h5556);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_cout", 32'(cout), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ov_drop", 32'(out_valid), 32'd0);
        check("bp_rdy_rise", 32'(in_ready), 32'd1);

        // Reset during the second ADD cycle abandons the operation.
        in1 = 16'h1111; in2 = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_no_out_valid", seen, 0);
        do_add("t7", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

        // Back-to-back throughput with in_valid and out_ready held high.
        in1 = 16'h0002; in2 = 16'h0003; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0;
        acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 40 && n_acc < 2; c++) begin
            if (in_ready) begin
                acc[n_acc] = c;
                n_acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_spacing", acc[1] - acc[0], NIBBLES + 2);
        seen = 0;
        while (!in_ready && seen < 20) begin
            tick();
            seen++;
        end
        check("b2b_drain", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
